// File: rtl/load_store_unit_pkg.sv
// Shared widths and FSM state encoding for the data-memory
// load/store initiator of the 19-bit core.
package constants;

    localparam int WORD_SIZE = 19;
    localparam int DM_ADDR_W = 10;
    localparam int TAG_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle and the CPU-side
// data-memory bus used by the load/store unit.
interface lsu_req_if;

    logic                           req_valid;
    logic                           req_ready;
    logic                           req_is_store;
    logic [constants::WORD_SIZE-1:0] req_addr;
    logic [constants::WORD_SIZE-1:0] req_wdata;
    logic [constants::TAG_W-1:0]     req_tag;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [constants::WORD_SIZE-1:0] rsp_rdata;
    logic [constants::TAG_W-1:0]     rsp_tag;
    logic                           rsp_err;

    modport master (
        output req_valid, req_is_store, req_addr,
        output req_wdata, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata,
        input  rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_is_store, req_addr,
        input  req_wdata, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata,
        output rsp_tag, rsp_err
    );

endinterface

interface dm_bus_if;

    logic                           WR_EN_DM;
    logic                           RD_EN_DM;
    logic [constants::DM_ADDR_W-1:0] dm_address;
    logic [constants::WORD_SIZE-1:0] dm_data_in;
    logic [constants::WORD_SIZE-1:0] dm_data_out;

    modport master (
        output WR_EN_DM, RD_EN_DM, dm_address, dm_data_in,
        input  dm_data_out
    );

    modport slave (
        input  WR_EN_DM, RD_EN_DM, dm_address, dm_data_in,
        output dm_data_out
    );

endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: accepts one request,
// drives data memory, and returns a tagged response.
module load_store_unit
    import constants::*;
(
    input  logic     CLK,
    input  logic     RESET,
    lsu_req_if.slave req,
    dm_bus_if.master dm
);

    lsu_state_t state_q, state_d;

    logic [DM_ADDR_W-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 err_q;
    logic                 wr_en_q;
    logic                 rd_en_q;
    logic                 accept;
    logic                 fault;

    assign accept = req.req_valid && (state_q == IDLE);
    assign fault  = |req.req_addr[WORD_SIZE-1:DM_ADDR_W];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    if (fault)
                        state_d = RESP;
                    else if (req.req_is_store)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            WRITE: state_d = RESP;
            READ:  state_d = CAPT;
            CAPT:  state_d = RESP;
            RESP: begin
                if (req.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables come from next-state so they are clean register outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= (state_d == WRITE);
            rd_en_q <= (state_d == READ);
            if (accept) begin
                addr_q  <= req.req_addr[DM_ADDR_W-1:0];
                wdata_q <= req.req_wdata;
                tag_q   <= req.req_tag;
                err_q   <= fault;
                rdata_q <= '0;
            end else if (state_q == CAPT) begin
                rdata_q <= dm.dm_data_out;
            end
        end
    end

    assign req.req_ready = (state_q == IDLE);
    assign req.rsp_valid = (state_q == RESP);
    assign req.rsp_rdata = rdata_q;
    assign req.rsp_tag   = tag_q;
    assign req.rsp_err   = err_q;

    assign dm.WR_EN_DM   = wr_en_q;
    assign dm.RD_EN_DM   = rd_en_q;
    assign dm.dm_address = addr_q;
    assign dm.dm_data_in = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit timing,
// faults, backpressure and response ordering.
module tb_load_store_unit;

    logic clk;
    logic rst_n;

    lsu_req_if rq ();
    dm_bus_if  dm ();

    load_store_unit dut (
        .CLK   (clk),
        .RESET (rst_n),
        .req   (rq),
        .dm    (dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] mem [1024];

    always @(posedge clk) begin
        if (dm.WR_EN_DM) mem[dm.dm_address] <= dm.dm_data_in;
        if (dm.RD_EN_DM) dm.dm_data_out <= mem[dm.dm_address];
    end

    int wr_cnt = 0;
    int rd_cnt = 0;

    always @(negedge clk) begin
        if (dm.WR_EN_DM) wr_cnt <= wr_cnt + 1;
        if (dm.RD_EN_DM) rd_cnt <= rd_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic st,
                          input logic [18:0] a,
                          input logic [18:0] d,
                          input logic [2:0] t);
        int n;
        rq.req_is_store = st;
        rq.req_addr     = a;
        rq.req_wdata    = d;
        rq.req_tag      = t;
        rq.req_valid    = 1'b1;
        n = 0;
        while (!rq.req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(n < 20), 32'd1);
        step();
        rq.req_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  tag;
        logic        err;
        logic [18:0] rdata;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    logic [18:0] shadow [1024];
    bit          known  [1024];

    int s_wr;
    int s_rd;

    initial begin
        rst_n           = 1'b0;
        rq.req_valid    = 1'b0;
        rq.req_is_store = 1'b0;
        rq.req_addr     = '0;
        rq.req_wdata    = '0;
        rq.req_tag      = '0;
        rq.rsp_ready    = 1'b1;
        repeat (3) step();
        chk("rst_wr_en", 32'(dm.WR_EN_DM), 0);
        chk("rst_rd_en", 32'(dm.RD_EN_DM), 0);
        rst_n = 1'b1;
        step();
        chk("rst_req_ready", 32'(rq.req_ready), 1);
        chk("rst_rsp_valid", 32'(rq.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rq.rsp_rdata), 0);
        chk("rst_rsp_tag", 32'(rq.rsp_tag), 0);
        chk("rst_rsp_err", 32'(rq.rsp_err), 0);
        chk("rst_dm_addr", 32'(dm.dm_address), 0);
        chk("rst_dm_din", 32'(dm.dm_data_in), 0);

        // store 0x5A5A5 to 0x012
        s_wr = wr_cnt;
        do_req(1'b1, 19'h00012, 19'h5A5A5, 3'd1);
        chk("st_wr_en_t1", 32'(dm.WR_EN_DM), 1);
        chk("st_rd_en_t1", 32'(dm.RD_EN_DM), 0);
        chk("st_addr_t1", 32'(dm.dm_address), 32'h012);
        chk("st_din_t1", 32'(dm.dm_data_in), 32'h5A5A5);
        chk("st_ready_t1", 32'(rq.req_ready), 0);
        chk("st_valid_t1", 32'(rq.rsp_valid), 0);
        step();
        chk("st_wr_en_t2", 32'(dm.WR_EN_DM), 0);
        chk("st_valid_t2", 32'(rq.rsp_valid), 1);
        chk("st_rdata", 32'(rq.rsp_rdata), 0);
        chk("st_err", 32'(rq.rsp_err), 0);
        chk("st_tag", 32'(rq.rsp_tag), 1);
        step();
        chk("st_ready_back", 32'(rq.req_ready), 1);
        chk("st_wr_pulse", 32'(wr_cnt - s_wr), 1);
        shadow[12'h012] = 19'h5A5A5;
        known[12'h012]  = 1'b1;

        // load 0x012 tag 3
        do_req(1'b0, 19'h00012, 19'h0, 3'd3);
        chk("ld_rd_en_t1", 32'(dm.RD_EN_DM), 1);
        chk("ld_wr_en_t1", 32'(dm.WR_EN_DM), 0);
        chk("ld_valid_t1", 32'(rq.rsp_valid), 0);
        step();
        chk("ld_rd_en_t2", 32'(dm.RD_EN_DM), 0);
        chk("ld_valid_t2", 32'(rq.rsp_valid), 0);
        step();
        chk("ld_valid_t3", 32'(rq.rsp_valid), 1);
        chk("ld_rdata", 32'(rq.rsp_rdata), 32'h5A5A5);
        chk("ld_tag", 32'(rq.rsp_tag), 3);
        chk("ld_err", 32'(rq.rsp_err), 0);
        step();
        chk("ld_ready_back", 32'(rq.req_ready), 1);
        chk("ld_valid_off", 32'(rq.rsp_valid), 0);

        // address fault
        s_wr = wr_cnt;
        s_rd = rd_cnt;
        do_req(1'b0, 19'h00400, 19'h0, 3'd5);
        chk("flt_valid_t1", 32'(rq.rsp_valid), 1);
        chk("flt_err", 32'(rq.rsp_err), 1);
        chk("flt_rdata", 32'(rq.rsp_rdata), 0);
        chk("flt_tag", 32'(rq.rsp_tag), 5);
        step();
        step();
        chk("flt_ready_back", 32'(rq.req_ready), 1);
        chk("flt_no_wr", 32'(wr_cnt - s_wr), 0);
        chk("flt_no_rd", 32'(rd_cnt - s_rd), 0);

        // boundary 0x3FF, then backpressured load
        do_req(1'b1, 19'h003FF, 19'h12345, 3'd2);
        step();
        chk("b3ff_st_valid", 32'(rq.rsp_valid), 1);
        chk("b3ff_st_err", 32'(rq.rsp_err), 0);
        step();
        shadow[10'h3FF] = 19'h12345;
        known[10'h3FF]  = 1'b1;
        rq.rsp_ready = 1'b0;
        s_wr = wr_cnt;
        s_rd = rd_cnt;
        do_req(1'b0, 19'h003FF, 19'h0, 3'd6);
        step();
        step();
        chk("bp_valid", 32'(rq.rsp_valid), 1);
        chk("bp_rdata", 32'(rq.rsp_rdata), 32'h12345);
        chk("bp_err", 32'(rq.rsp_err), 0);
        rq.req_is_store = 1'b1;
        rq.req_addr     = 19'h0;
        rq.req_wdata    = 19'h1;
        rq.req_tag      = 3'd0;
        rq.req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(rq.rsp_valid), 1);
            chk("bp_hold_rdata", 32'(rq.rsp_rdata), 32'h12345);
            chk("bp_hold_tag", 32'(rq.rsp_tag), 6);
            chk("bp_hold_err", 32'(rq.rsp_err), 0);
            chk("bp_hold_ready", 32'(rq.req_ready), 0);
        end
        rq.req_valid = 1'b0;
        rq.rsp_ready = 1'b1;
        step();
        chk("bp_release", 32'(rq.req_ready), 1);
        chk("bp_one_rd", 32'(rd_cnt - s_rd), 1);
        chk("bp_no_wr", 32'(wr_cnt - s_wr), 0);

        // boundary 0x000
        do_req(1'b1, 19'h00000, 19'h7FFFF, 3'd4);
        step();
        step();
        shadow[0] = 19'h7FFFF;
        known[0]  = 1'b1;
        do_req(1'b0, 19'h00000, 19'h0, 3'd7);
        step();
        step();
        chk("b000_valid", 32'(rq.rsp_valid), 1);
        chk("b000_rdata", 32'(rq.rsp_rdata), 32'h7FFFF);
        chk("b000_err", 32'(rq.rsp_err), 0);
        chk("b000_tag", 32'(rq.rsp_tag), 7);
        step();

        // asynchronous reset while in READ
        do_req(1'b0, 19'h00012, 19'h0, 3'd1);
        chk("mid_rd_en", 32'(dm.RD_EN_DM), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(dm.RD_EN_DM), 0);
        chk("mid_rst_valid", 32'(rq.rsp_valid), 0);
        chk("mid_rst_ready", 32'(rq.req_ready), 1);
        chk("mid_rst_addr", 32'(dm.dm_address), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(rq.req_ready), 1);
        chk("post_rst_valid", 32'(rq.rsp_valid), 0);
        chk("post_rst_tag", 32'(rq.rsp_tag), 0);

        // randomized protocol run
        begin
            int   issued;
            int   done;
            int   cyc;
            bit   acc;
            exp_t e;
            logic [9:0] ia;
            issued = 0;
            done   = 0;
            cyc    = 0;
            while (done < 200 && cyc < 20000) begin
                if (!rq.req_valid && issued < 200
                    && $urandom_range(0, 3) != 0) begin
                    rq.req_is_store = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0)
                        rq.req_addr = 19'($urandom_range(
                            19'h00400, 19'h7FFFF));
                    else if ($urandom_range(0, 1) == 0)
                        rq.req_addr = 19'($urandom_range(0, 15));
                    else
                        rq.req_addr = 19'($urandom_range(
                            10'h3F0, 10'h3FF));
                    rq.req_wdata = 19'($urandom);
                    rq.req_tag   = 3'($urandom_range(0, 7));
                    rq.req_valid = 1'b1;
                end
                rq.rsp_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("excl_en", 32'(dm.WR_EN_DM && dm.RD_EN_DM), 0);
                acc = rq.req_valid && rq.req_ready;
                if (acc) begin
                    ia         = rq.req_addr[9:0];
                    e.tag      = rq.req_tag;
                    e.err      = |rq.req_addr[18:10];
                    e.rdata    = '0;
                    e.chk_data = 1'b1;
                    if (!e.err && rq.req_is_store) begin
                        shadow[ia] = rq.req_wdata;
                        known[ia]  = 1'b1;
                    end else if (!e.err) begin
                        e.rdata    = shadow[ia];
                        e.chk_data = known[ia];
                    end
                    sb.push_back(e);
                    issued++;
                end
                if (rq.rsp_valid && rq.rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("rsp_spurious", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rnd_tag", 32'(rq.rsp_tag), 32'(e.tag));
                        chk("rnd_err", 32'(rq.rsp_err), 32'(e.err));
                        if (e.chk_data)
                            chk("rnd_rdata", 32'(rq.rsp_rdata),
                                32'(e.rdata));
                    end
                    done++;
                end
                @(posedge clk);
                #1;
                if (acc) rq.req_valid = 1'b0;
                cyc++;
            end
            chk("rnd_done", 32'(done), 200);
            chk("rnd_sb_empty", 32'(sb.size()), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
